id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised decode stage for the 16-bit pipelined core. It combines instruction decode, register-file source selection, immediate extension and branch resolution with a registered ID/EX pipeline register. Upstream (IF/ID) and downstream (EX) are connected through valid/ready handshakes. It accepts stall (hazard) and flush requests and, optionally, keeps a performance counter.

Parameters:
WORD_LEN, 16, datapath width; must be at least IMM_LEN
REG_ADDR_LEN, 4, register-file address width; instruction uses fixed 4-bit fields, zero-extended if REG_ADDR_LEN>4
IMM_LEN, 8, immediate field width taken from instruction[IMM_LEN-1:0]
EXE_CMD_LEN, 4, execute command width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  instruction/pc/reg values valid from IF/ID
in_ready  out  1  stage accepts the current instruction this cycle
instruction  in  16  opcode[15:12], rd/src1[11:8], rs2[7:4], imm[7:0]
pc_in  in  WORD_LEN  pc+1 of the instruction
reg1, reg2  in  WORD_LEN  register-file read data for src1, src2_rf
hazard_detected  in  1  from hazard unit; forces a bubble
flush  in  1  kill the ID/EX contents and the current ID instruction
src1, src2_rf  out  REG_ADDR_LEN  combinational register-file read addresses
br_taken  out  1  combinational; branch resolved taken on accept
br_target  out  WORD_LEN  pc_in + sign-extended imm
out_valid  out  1  ID/EX register holds a real instruction
out_ready  in  1  EX consumes the ID/EX register
ex_cmd  out  EXE_CMD_LEN  registered ALU command
wb_en, mem_r_en, mem_w_en  out  1 each  registered control bits
is_imm  out  1  registered; val2 is the immediate
dest, fw_src1, fw_src2  out  REG_ADDR_LEN  registered; fw_src2=0 when is_imm
val1, val2, st_data  out  WORD_LEN  registered operands; st_data=reg2 for ST
illegal  out  1  registered; the opcode was undefined

Behaviour:
- Opcode decode, giving ex_cmd / wb / mr / mw / imm:
  - 0 NOP: ex 0, no writeback, no memory.
  - 1 ADD ex0, 2 SUB ex1, 3 AND ex2, 4 OR ex3: wb=1.
  - 5 ADDI: ex0, wb=1, imm=1.
  - 6 LD: ex0, wb=1, mr=1, imm=1.
  - 7 ST: ex0, mw=1, imm=1.
  - 8 BEZ: taken if reg1==0.
  - 9 BNE: taken if reg1!=reg2.
  - A JMP: always taken.
  - B-F: NOP with illegal=1.
- Source select: src1=instruction[11:8]. src2_rf=instruction[11:8] for ST/BNE, else instruction[7:4].
- Immediate: sign-extend from IMM_LEN to WORD_LEN.
- Accept: accept = in_valid && in_ready. in_ready = !hazard_detected && !flush && (!out_valid || out_ready).
- br_taken = accept && branch condition true; zero otherwise.
- br_target arithmetic wraps modulo 2^WORD_LEN.
- ID/EX register update, in priority order:
  1. flush: out_valid<=0.
  2. accept: load all decoded fields and set out_valid<=1. Branches and NOP load with wb/mr/mw=0.
  3. out_ready with no accept (including the hazard case): out_valid<=0, i.e. a bubble.
  4. Otherwise hold all fields.
- Latency: one cycle from accept to out_valid.
- Under backpressure (out_valid=1, out_ready=0) all registered outputs are held stable.
- Reset (rst=0, asynchronous): out_valid=0, illegal=0, and all registered outputs 0. Combinational outputs follow their inputs.
- Reset released mid-operation: the first accept can occur on the first rising edge after rst=1.
- hazard_detected and flush in the same cycle: flush wins, so the result is a bubble.

Optional Feature:
Macro ID_PERF_CNT_EN.
- When defined, adds output stall_cnt (16 bits).
- stall_cnt increments each cycle with in_valid=1 and in_ready=0.
- It saturates at 0xFFFF, is cleared on flush, and resets to 0.
- When undefined, the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then ADD R3,R1,R2 (instr 0x1312, reg1=5, reg2=7), out_ready=1: next cycle out_valid=1, ex_cmd=0, wb_en=1, dest=3, val1=5, val2=7, fw_src2=1.
- ADDI R2, imm=0xF0, reg1=0x0010: val2=0xFFF0, is_imm=1, fw_src2=0.
- BNE with reg1=4, reg2=9, pc_in=0x0020, imm=0xFE: br_taken=1 in the accept cycle, br_target=0x001E. With reg1=reg2: br_taken=0.
- hazard_detected=1 for 2 cycles with in_valid=1:
  - in_ready=0 and out_valid=0 on both following edges.
  - The instruction is accepted on the cycle hazard drops.
  - With ID_PERF_CNT_EN, stall_cnt=2.
- out_ready=0 for 3 cycles after LD loaded: all registered outputs remain constant and in_ready=0. The next instruction loads on the cycle out_ready returns to 1.
- flush asserted together with hazard, and separately with a valid accept: out_valid=0 next cycle and br_taken=0. Opcode 0xC afterwards: illegal=1, wb_en=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: 16-bit core decode stage with a registered ID/EX pipeline register.
// Decodes the opcode, selects register-file read addresses, sign-extends the
// immediate, resolves branches and hands decoded fields to EX over valid/ready.
// Optional feature macro: ID_PERF_CNT_EN (adds the 16-bit stall_cnt output).
module id_stage_pipe #(
    parameter int unsigned WORD_LEN     = 16,
    parameter int unsigned REG_ADDR_LEN = 4,
    parameter int unsigned IMM_LEN      = 8,
    parameter int unsigned EXE_CMD_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             instruction,
    input  logic [WORD_LEN-1:0]     pc_in,
    input  logic [WORD_LEN-1:0]     reg1,
    input  logic [WORD_LEN-1:0]     reg2,
    input  logic                    hazard_detected,
    input  logic                    flush,
    output logic [REG_ADDR_LEN-1:0] src1,
    output logic [REG_ADDR_LEN-1:0] src2_rf,
    output logic                    br_taken,
    output logic [WORD_LEN-1:0]     br_target,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXE_CMD_LEN-1:0]  ex_cmd,
    output logic                    wb_en,
    output logic                    mem_r_en,
    output logic                    mem_w_en,
    output logic                    is_imm,
    output logic [REG_ADDR_LEN-1:0] dest,
    output logic [REG_ADDR_LEN-1:0] fw_src1,
    output logic [REG_ADDR_LEN-1:0] fw_src2,
    output logic [WORD_LEN-1:0]     val1,
    output logic [WORD_LEN-1:0]     val2,
    output logic [WORD_LEN-1:0]     st_data,
`ifdef ID_PERF_CNT_EN
    output logic [15:0]             stall_cnt,
`endif
    output logic                    illegal
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEZ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;

    typedef struct packed {
        logic                    valid;
        logic [EXE_CMD_LEN-1:0]  ex_cmd;
        logic                    wb_en;
        logic                    mem_r_en;
        logic                    mem_w_en;
        logic                    is_imm;
        logic                    illegal;
        logic [REG_ADDR_LEN-1:0] dest;
        logic [REG_ADDR_LEN-1:0] fw_src1;
        logic [REG_ADDR_LEN-1:0] fw_src2;
        logic [WORD_LEN-1:0]     val1;
        logic [WORD_LEN-1:0]     val2;
        logic [WORD_LEN-1:0]     st_data;
    } idex_t;

    idex_t idex_q, idex_d;

    logic [3:0]             opcode;
    logic [WORD_LEN-1:0]    imm_ext;
    logic                   accept;
    logic [EXE_CMD_LEN-1:0] dec_ex;
    logic                   dec_wb;
    logic                   dec_mr;
    logic                   dec_mw;
    logic                   dec_imm;
    logic                   dec_ill;
    logic                   dec_br_cond;
    logic                   dec_src2_rd;

    assign opcode  = instruction[15:12];
    assign imm_ext = WORD_LEN'($signed(instruction[IMM_LEN-1:0]));

    // Opcode decode into control bits and branch condition.
    always_comb begin
        dec_ex      = '0;
        dec_wb      = 1'b0;
        dec_mr      = 1'b0;
        dec_mw      = 1'b0;
        dec_imm     = 1'b0;
        dec_ill     = 1'b0;
        dec_br_cond = 1'b0;
        dec_src2_rd = 1'b0;
        case (opcode)
            OP_NOP: begin
            end
            OP_ADD: dec_wb = 1'b1;
            OP_SUB: begin
                dec_ex = EXE_CMD_LEN'(1);
                dec_wb = 1'b1;
            end
            OP_AND: begin
                dec_ex = EXE_CMD_LEN'(2);
                dec_wb = 1'b1;
            end
            OP_OR: begin
                dec_ex = EXE_CMD_LEN'(3);
                dec_wb = 1'b1;
            end
            OP_ADDI: begin
                dec_wb  = 1'b1;
                dec_imm = 1'b1;
            end
            OP_LD: begin
                dec_wb  = 1'b1;
                dec_mr  = 1'b1;
                dec_imm = 1'b1;
            end
            OP_ST: begin
                dec_mw      = 1'b1;
                dec_imm     = 1'b1;
                dec_src2_rd = 1'b1;
            end
            OP_BEZ: dec_br_cond = (reg1 == '0);
            OP_BNE: begin
                dec_br_cond = (reg1 != reg2);
                dec_src2_rd = 1'b1;
            end
            OP_JMP: dec_br_cond = 1'b1;
            default: dec_ill = 1'b1;
        endcase
    end

    // Register-file addresses, handshake and branch resolution.
    assign src1      = REG_ADDR_LEN'(instruction[11:8]);
    assign src2_rf   = dec_src2_rd ? REG_ADDR_LEN'(instruction[11:8])
                                   : REG_ADDR_LEN'(instruction[7:4]);
    assign in_ready  = !hazard_detected && !flush && (!idex_q.valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign br_taken  = accept && dec_br_cond;
    assign br_target = pc_in + imm_ext;

    // ID/EX next state: flush, then load, then bubble on drain, else hold.
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d.valid = 1'b0;
        end else if (accept) begin
            idex_d.valid    = 1'b1;
            idex_d.ex_cmd   = dec_ex;
            idex_d.wb_en    = dec_wb;
            idex_d.mem_r_en = dec_mr;
            idex_d.mem_w_en = dec_mw;
            idex_d.is_imm   = dec_imm;
            idex_d.illegal  = dec_ill;
            idex_d.dest     = src1;
            idex_d.fw_src1  = src1;
            idex_d.fw_src2  = dec_imm ? '0 : src2_rf;
            idex_d.val1     = reg1;
            idex_d.val2     = dec_imm ? imm_ext : reg2;
            idex_d.st_data  = dec_mw ? reg2 : '0;
        end else if (out_ready) begin
            idex_d.valid = 1'b0;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign out_valid = idex_q.valid;
    assign ex_cmd    = idex_q.ex_cmd;
    assign wb_en     = idex_q.wb_en;
    assign mem_r_en  = idex_q.mem_r_en;
    assign mem_w_en  = idex_q.mem_w_en;
    assign is_imm    = idex_q.is_imm;
    assign illegal   = idex_q.illegal;
    assign dest      = idex_q.dest;
    assign fw_src1   = idex_q.fw_src1;
    assign fw_src2   = idex_q.fw_src2;
    assign val1      = idex_q.val1;
    assign val2      = idex_q.val2;
    assign st_data   = idex_q.st_data;

`ifdef ID_PERF_CNT_EN
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a valid instruction is held off.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (in_valid && !in_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed scenarios plus randomized traffic against a
// behavioural model of the decode stage. Build with ID_PERF_CNT_EN to also
// cover stall_cnt.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instruction;
    logic [15:0] pc_in;
    logic [15:0] reg1;
    logic [15:0] reg2;
    logic        hazard_detected;
    logic        flush;
    logic [3:0]  src1;
    logic [3:0]  src2_rf;
    logic        br_taken;
    logic [15:0] br_target;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ex_cmd;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        is_imm;
    logic [3:0]  dest;
    logic [3:0]  fw_src1;
    logic [3:0]  fw_src2;
    logic [15:0] val1;
    logic [15:0] val2;
    logic [15:0] st_data;
    logic        illegal;
`ifdef ID_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_in(pc_in),
        .reg1(reg1), .reg2(reg2),
        .hazard_detected(hazard_detected), .flush(flush),
        .src1(src1), .src2_rf(src2_rf),
        .br_taken(br_taken), .br_target(br_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .ex_cmd(ex_cmd), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .is_imm(is_imm), .dest(dest), .fw_src1(fw_src1), .fw_src2(fw_src2),
        .val1(val1), .val2(val2), .st_data(st_data),
`ifdef ID_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .illegal(illegal)
    );

    // Expected ID/EX contents as seen on the registered outputs.
    typedef struct packed {
        logic        valid;
        logic [3:0]  ex;
        logic        wb, mr, mw, imm, ill;
        logic [3:0]  dest, f1, f2;
        logic [15:0] v1, v2, st;
    } exp_t;

    exp_t        m;
    logic [15:0] m_cnt;

    function automatic exp_t dut_view();
        exp_t v;
        v.valid = out_valid; v.ex = ex_cmd;
        v.wb = wb_en; v.mr = mem_r_en; v.mw = mem_w_en; v.imm = is_imm; v.ill = illegal;
        v.dest = dest; v.f1 = fw_src1; v.f2 = fw_src2;
        v.v1 = val1; v.v2 = val2; v.st = st_data;
        return v;
    endfunction

    // Immediate as a signed integer value.
    function automatic int sext_imm(input logic [15:0] ins);
        int v;
        v = int'(ins[7:0]);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic logic [3:0] ref_src2(input logic [15:0] ins);
        int op;
        op = int'(ins[15:12]);
        return (op == 7 || op == 9) ? ins[11:8] : ins[7:4];
    endfunction

    function automatic logic ref_cond(input logic [15:0] ins, input logic [15:0] r1,
                                      input logic [15:0] r2);
        int op;
        op = int'(ins[15:12]);
        if (op == 8)  return r1 == 16'd0;
        if (op == 9)  return r1 != r2;
        return op == 10;
    endfunction

    function automatic logic [15:0] ref_target(input logic [15:0] pc, input logic [15:0] ins);
        return 16'(int'(pc) + sext_imm(ins));
    endfunction

    function automatic logic ref_ready();
        return !hazard_detected && !flush && (!m.valid || out_ready);
    endfunction

    function automatic exp_t ref_load(input logic [15:0] ins, input logic [15:0] r1,
                                      input logic [15:0] r2);
        exp_t e;
        int   op;
        op      = int'(ins[15:12]);
        e       = '0;
        e.valid = 1'b1;
        e.ill   = (op >= 11);
        e.wb    = (op >= 1 && op <= 6);
        e.ex    = (op >= 1 && op <= 4) ? 4'(op - 1) : 4'd0;
        e.imm   = (op >= 5 && op <= 7);
        e.mr    = (op == 6);
        e.mw    = (op == 7);
        e.dest  = ins[11:8];
        e.f1    = ins[11:8];
        e.f2    = e.imm ? 4'd0 : ref_src2(ins);
        e.v1    = r1;
        e.v2    = e.imm ? 16'(sext_imm(ins)) : r2;
        e.st    = (op == 7) ? r2 : 16'd0;
        return e;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic rdy;
        rdy = ref_ready();
        if (flush) m_cnt = 16'd0;
        else if (in_valid && !rdy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (flush) m.valid = 1'b0;
        else if (in_valid && rdy) m = ref_load(instruction, reg1, reg2);
        else if (out_ready) m.valid = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic [15:0] r1, input logic [15:0] r2,
                         input logic haz, input logic fl, input logic ordy);
        in_valid = v; instruction = ins; pc_in = pc; reg1 = r1; reg2 = r2;
        hazard_detected = haz; flush = fl; out_ready = ordy;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        m = '0; m_cnt = 16'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (dut_view() !== exp_t'('0)) begin
            n_errors++; $display("FAIL reset_regs: got %h want 0", dut_view());
        end
        @(negedge clk) rst = 1'b1;
        m = '0; m_cnt = 16'd0;
        // Load an ADD, then reset asynchronously in the middle of a cycle.
        drive(1'b1, 16'h1312, 16'h0, 16'd5, 16'd7, 1'b0, 1'b0, 1'b1);
        tick();
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (dut_view() !== exp_t'('0)) begin
            n_errors++; $display("FAIL async_reset: got %h want 0", dut_view());
        end
        m = '0; m_cnt = 16'd0;
        @(negedge clk) rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick();
        e = '0; e.valid = 1'b1; e.wb = 1'b1; e.dest = 4'd3; e.f1 = 4'd3; e.f2 = 4'd1;
        e.v1 = 16'd5; e.v2 = 16'd7;
        n_checks++;
        if (dut_view() !== e) begin
            n_errors++; $display("FAIL first_accept_after_reset: got %h want %h", dut_view(), e);
        end
    endtask

    task automatic test_add();
        exp_t e;
        drive(1'b1, 16'h1312, 16'h0, 16'd5, 16'd7, 1'b0, 1'b0, 1'b1);
        tick();
        e = '0; e.valid = 1'b1; e.wb = 1'b1; e.dest = 4'd3; e.f1 = 4'd3; e.f2 = 4'd1;
        e.v1 = 16'd5; e.v2 = 16'd7;
        n_checks++;
        if (dut_view() !== e) begin
            n_errors++; $display("FAIL add: got %h want %h", dut_view(), e);
        end
    endtask

    task automatic test_addi();
        exp_t e;
        drive(1'b1, 16'h52F0, 16'h0, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b1);
        tick();
        e = '0; e.valid = 1'b1; e.wb = 1'b1; e.imm = 1'b1; e.dest = 4'd2; e.f1 = 4'd2;
        e.f2 = 4'd0; e.v1 = 16'h0010; e.v2 = 16'hFFF0;
        n_checks++;
        if (dut_view() !== e) begin
            n_errors++; $display("FAIL addi: got %h want %h", dut_view(), e);
        end
    endtask

    task automatic test_branch();
        drive(1'b1, 16'h94FE, 16'h0020, 16'd4, 16'd9, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if ({br_taken, br_target, src2_rf} !== {1'b1, 16'h001E, 4'd4}) begin
            n_errors++;
            $display("FAIL bne_taken: got %b %h %h want 1 001e 4", br_taken, br_target, src2_rf);
        end
        reg2 = 16'd4;
        #1;
        n_checks++;
        if (br_taken !== 1'b0) begin
            n_errors++; $display("FAIL bne_equal: got %b want 0", br_taken);
        end
        tick();
        n_checks++;
        if ({out_valid, wb_en, mem_r_en, mem_w_en} !== 4'b1000) begin
            n_errors++; $display("FAIL bne_regs: got %b%b%b%b want 1000",
                                 out_valid, wb_en, mem_r_en, mem_w_en);
        end
        // JMP wrapping below zero.
        drive(1'b1, 16'hA080, 16'h0001, 16'd3, 16'd3, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if ({br_taken, br_target} !== {1'b1, 16'hFF81}) begin
            n_errors++; $display("FAIL jmp_wrap: got %b %h want 1 ff81", br_taken, br_target);
        end
        tick();
        drive(1'b1, 16'h8000, 16'h0010, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (br_taken !== 1'b1) begin
            n_errors++; $display("FAIL bez_zero: got %b want 1", br_taken);
        end
        reg1 = 16'd1;
        #1;
        n_checks++;
        if (br_taken !== 1'b0) begin
            n_errors++; $display("FAIL bez_nonzero: got %b want 0", br_taken);
        end
        tick();
    endtask

    task automatic test_hazard();
        apply_reset();
        drive(1'b1, 16'h1312, 16'h0, 16'd5, 16'd7, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_errors++; $display("FAIL hazard_in_ready[%0d]: got %b want 0", k, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++; $display("FAIL hazard_out_valid[%0d]: got %b want 0", k, out_valid);
            end
        end
        hazard_detected = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, dest, val1} !== {1'b1, 4'd3, 16'd5}) begin
            n_errors++; $display("FAIL hazard_release: got %b %h %h want 1 3 0005",
                                 out_valid, dest, val1);
        end
`ifdef ID_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd2) begin
            n_errors++; $display("FAIL hazard_stall_cnt: got %0d want 2", stall_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        exp_t e;
        drive(1'b1, 16'h6A05, 16'h0, 16'h0100, 16'h0055, 1'b0, 1'b0, 1'b1);
        tick();
        e = '0; e.valid = 1'b1; e.wb = 1'b1; e.mr = 1'b1; e.imm = 1'b1;
        e.dest = 4'hA; e.f1 = 4'hA; e.v1 = 16'h0100; e.v2 = 16'h0005;
        drive(1'b1, 16'h2345, 16'h0, 16'h0011, 16'h0022, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready);
            end
            tick();
            n_checks++;
            if (dut_view() !== e) begin
                n_errors++; $display("FAIL bp_hold[%0d]: got %h want %h", k, dut_view(), e);
            end
        end
        out_ready = 1'b1;
        tick();
        e = '0; e.valid = 1'b1; e.ex = 4'd1; e.wb = 1'b1; e.dest = 4'd3; e.f1 = 4'd3;
        e.f2 = 4'd4; e.v1 = 16'h0011; e.v2 = 16'h0022;
        n_checks++;
        if (dut_view() !== e) begin
            n_errors++; $display("FAIL bp_resume: got %h want %h", dut_view(), e);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h1312, 16'h0, 16'd5, 16'd7, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 16'hA000, 16'h0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
        #1;
        n_checks++;
        if ({br_taken, in_ready} !== 2'b00) begin
            n_errors++; $display("FAIL flush_hazard_comb: got %b%b want 00", br_taken, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_hazard: got %b want 0", out_valid);
        end
        drive(1'b1, 16'h1312, 16'h0, 16'd5, 16'd7, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 16'hA000, 16'h0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (br_taken !== 1'b0) begin
            n_errors++; $display("FAIL flush_accept_br: got %b want 0", br_taken);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_accept: got %b want 0", out_valid);
        end
`ifdef ID_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_errors++; $display("FAIL flush_clears_cnt: got %0d want 0", stall_cnt);
        end
`endif
        drive(1'b1, 16'hC123, 16'h0, 16'd1, 16'd2, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if ({out_valid, illegal, wb_en, ex_cmd} !== {3'b110, 4'd0}) begin
            n_errors++; $display("FAIL illegal_op: got %b%b%b %h want 110 0",
                                 out_valid, illegal, wb_en, ex_cmd);
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] pc;
        logic        exp_rdy;
        logic [36:0] exp_c;
        logic [36:0] got_c;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            ins = 16'($urandom);
            pc  = 16'($urandom);
            r1  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            r2  = ($urandom_range(0, 3) == 0) ? r1 : 16'($urandom);
            drive($urandom_range(0, 9) < 8, ins, pc, r1, r2,
                  $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7);
            #1;
            exp_rdy = ref_ready();
            exp_c = {exp_rdy, ins[11:8], ref_src2(ins),
                     in_valid && exp_rdy && ref_cond(ins, r1, r2), ref_target(pc, ins)};
            got_c = {in_ready, src1, src2_rf, br_taken, br_target};
            n_checks++;
            if (got_c !== exp_c) begin
                n_errors++; $display("FAIL rand_comb[%0d]: got %h want %h", i, got_c, exp_c);
            end
            tick();
            n_checks++;
            if (dut_view() !== m) begin
                n_errors++; $display("FAIL rand_regs[%0d]: got %h want %h", i, dut_view(), m);
            end
`ifdef ID_PERF_CNT_EN
            n_checks++;
            if (stall_cnt !== m_cnt) begin
                n_errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, stall_cnt, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        m = '0;
        m_cnt = 16'd0;
        test_reset();
        test_add();
        test_addi();
        test_branch();
        test_hazard();
        test_backpressure();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
